// File: rtl/ysyx_24100012_arb_pkg.sv
// Shared encodings and width defaults for the IFU/LSU memory arbiter.
package ysyx_24100012_arb_pkg;

    localparam int ARB_ADDR_WIDTH = 32;
    localparam int ARB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_24100012_arb_pick.sv
// Combinational grant selector for the memory arbiter.
// YSYX_24100012_ARB_RR_EN selects round-robin; otherwise the LSU has fixed priority.
module ysyx_24100012_arb_pick
    import ysyx_24100012_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  arb_owner_e last_owner,
    output logic       gnt_ifu,
    output logic       gnt_lsu
);

`ifdef YSYX_24100012_ARB_RR_EN
    // On contention, the requester that did not win the previous grant goes first.
    assign gnt_lsu = lsu_valid & (~ifu_valid | (last_owner == OWN_IFU));
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign gnt_lsu = lsu_valid;
`endif

    assign gnt_ifu = ifu_valid & ~gnt_lsu;

endmodule

// File: rtl/ysyx_24100012_mem_arbiter.sv
// Shares one downstream memory port between IFU and LSU, one transaction at a time.
// Grant policy is set by YSYX_24100012_ARB_RR_EN (see ysyx_24100012_arb_pick).
module ysyx_24100012_mem_arbiter
    import ysyx_24100012_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic                    lsu_wen,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    proto_err,
    output arb_state_e              dbg_state
);

    // Handshake: a request transfers in a cycle where valid and ready are both 1.
    // Upstream readys depend combinationally on the valids (IDLE only); mem_req_valid
    // and the mem_* fields stay constant until mem_req_ready is seen.

    arb_state_e state, state_nxt;
    arb_owner_e owner, last_owner, grant_owner;
    logic       gnt_ifu, gnt_lsu, grant;

    ysyx_24100012_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_owner (last_owner),
        .gnt_ifu    (gnt_ifu),
        .gnt_lsu    (gnt_lsu)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        grant         = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so no ready escapes while reset is held.
                ifu_req_ready = rst & gnt_ifu;
                lsu_req_ready = rst & gnt_lsu;
                grant         = ifu_req_ready | lsu_req_ready;
                if (grant) state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                if (mem_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_owner = gnt_lsu ? OWN_LSU : OWN_IFU;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner         <= OWN_IFU;
            last_owner    <= OWN_IFU;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rdata     <= '0;
            proto_err     <= 1'b0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if (grant) begin
                owner      <= grant_owner;
                last_owner <= grant_owner;
                mem_wen    <= gnt_lsu & lsu_wen;
                mem_addr   <= gnt_lsu ? lsu_addr : ifu_addr;
                mem_wdata  <= gnt_lsu ? lsu_wdata : '0;
                mem_wmask  <= gnt_lsu ? lsu_wmask : '0;
            end
            if (state == RESP && mem_rsp_valid) begin
                if (owner == OWN_LSU) begin
                    lsu_rsp_valid <= 1'b1;
                    lsu_rdata     <= mem_rdata;
                end else begin
                    ifu_rsp_valid <= 1'b1;
                    ifu_rdata     <= mem_rdata;
                end
            end
            // A response with no transaction waiting for it is a protocol violation.
            if (state != RESP && mem_rsp_valid) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Self-checking bench for ysyx_24100012_mem_arbiter: vector table plus multi-cycle sequences.
module tb_ysyx_24100012_mem_arbiter;
    import ysyx_24100012_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int NV = 9;

`ifdef YSYX_24100012_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid;
    logic [AW-1:0] ifu_addr = '0;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0, lsu_req_ready, lsu_rsp_valid, lsu_wen = 1'b0;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0, lsu_rdata;
    logic [MW-1:0] lsu_wmask = '0;
    logic          mem_req_valid, mem_req_ready = 1'b0, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic [MW-1:0] mem_wmask;
    logic          mem_rsp_valid = 1'b0;
    logic          busy, proto_err;
    arb_state_e    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];   // {owner_is_lsu, rdata}

    typedef struct {
        logic          ifu_v;
        logic [AW-1:0] ifu_addr;
        logic          lsu_v;
        logic          lsu_wen;
        logic [AW-1:0] lsu_addr;
        logic [DW-1:0] lsu_wdata;
        logic [MW-1:0] lsu_wmask;
        logic [DW-1:0] rdata;
        logic          exp_lsu;
        logic          exp_wen;
        logic [AW-1:0] exp_addr;
        logic [MW-1:0] exp_wmask;
    } vec_t;

    vec_t vecs[NV];

    ysyx_24100012_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ifu_v, input logic [AW-1:0] ia,
                                input logic lsu_v, input logic wen, input logic [AW-1:0] la,
                                input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                                input logic [DW-1:0] rd, input logic exp_lsu);
        vec_t v;
        v.ifu_v = ifu_v; v.ifu_addr = ia;
        v.lsu_v = lsu_v; v.lsu_wen = wen; v.lsu_addr = la; v.lsu_wdata = wd; v.lsu_wmask = wm;
        v.rdata = rd;
        v.exp_lsu   = exp_lsu;
        v.exp_wen   = exp_lsu ? wen : 1'b0;
        v.exp_addr  = exp_lsu ? la : ia;
        v.exp_wmask = exp_lsu ? wm : '0;
        return v;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [DW:0] e;
        #1;
        if (ifu_rsp_valid || lsu_rsp_valid) begin
            chk("rsp_onehot", {63'd0, ifu_rsp_valid & lsu_rsp_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {63'd0, ifu_rsp_valid | lsu_rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {63'd0, lsu_rsp_valid}, {63'd0, e[DW]});
                chk("rsp_rdata", {32'd0, (lsu_rsp_valid ? lsu_rdata : ifu_rdata)}, {32'd0, e[DW-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Three cycles: grant in IDLE, REQ with zero-wait ready, RESP with immediate response.
    task automatic run_txn(input vec_t v, input bit chain, input bit prev_lsu);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_addr;
        lsu_req_valid = v.lsu_v; lsu_wen = v.lsu_wen; lsu_addr = v.lsu_addr;
        lsu_wdata = v.lsu_wdata; lsu_wmask = v.lsu_wmask;
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("ifu_req_ready", {63'd0, ifu_req_ready}, {63'd0, ~v.exp_lsu});
        chk("lsu_req_ready", {63'd0, lsu_req_ready}, {63'd0, v.exp_lsu});
        chk("idle_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        if (chain) begin
            chk("b2b_rsp_same_cycle", {63'd0, (prev_lsu ? lsu_rsp_valid : ifu_rsp_valid)}, 64'd1);
            chk("b2b_rsp_drained", 64'(exp_q.size()), 64'd0);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("req_mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("req_readys", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        chk("req_mem_addr", {32'd0, mem_addr}, {32'd0, v.exp_addr});
        chk("req_mem_wen", {63'd0, mem_wen}, {63'd0, v.exp_wen});
        chk("req_mem_wmask", {60'd0, mem_wmask}, {60'd0, v.exp_wmask});
        if (v.exp_lsu) chk("req_mem_wdata", {32'd0, mem_wdata}, {32'd0, v.lsu_wdata});
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = v.rdata;
        exp_q.push_back({v.exp_lsu, v.rdata});
        #1;
        chk("resp_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("resp_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic drain();
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("rsp_delivered", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic r;
        // Vector table; the bench tracks last_owner to predict contended grants.
        vecs[0] = mk(1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0010_0073, 1'b0);
        vecs[1] = mk(0, 32'h0, 1, 0, 32'h8000_0200, 32'h0, 4'hF, 32'h1122_3344, 1'b1);
        // last_owner = LSU: fixed priority picks LSU, round-robin picks IFU.
        vecs[2] = mk(1, 32'h8000_0004, 1, 1, 32'h8000_0300, 32'h5555_AAAA, 4'hC, 32'h0BAD_F00D, ~RR_EN);
        // last_owner = LSU (fixed) or IFU (round-robin): LSU wins either way.
        vecs[3] = mk(1, 32'h8000_0008, 1, 1, 32'h8000_0304, 32'h0123_4567, 4'h1, 32'h7654_3210, 1'b1);
        vecs[4] = mk(1, 32'h8000_000C, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 5; i < NV; i++) begin
            r = 1'($urandom_range(0, 1));
            vecs[i] = mk(~r, {$urandom} & 32'hFFFF_FFFC, r, 1'($urandom_range(0, 1)),
                         {$urandom} & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)), $urandom, r);
        end

        // Reset: everything low even with requests pending.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_readys", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b1;

        // Back-to-back table-driven transactions, 3-cycle throughput.
        for (int i = 0; i < NV; i++)
            run_txn(vecs[i], i > 0, (i > 0) ? vecs[i-1].exp_lsu : 1'b0);
        drain();

        // Store with a 3-cycle stall; IFU waits and is granted on the response cycle.
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1;
        chk("st_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_addr = 32'h0; lsu_wmask = 4'h0;
            ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
            mem_req_ready = (c == 3);
            #1;
            chk("st_req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("st_fields", {mem_wen, mem_wmask, mem_addr, mem_wdata[26:0]},
                {1'b1, 4'b0011, 32'h8000_0100, 27'h6AD_BEEF});
            chk("st_ifu_ready_held", {63'd0, ifu_req_ready}, 64'd0);
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        #1;
        chk("st_resp_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("st_ifu_granted_on_rsp", {62'd0, ifu_req_ready, lsu_rsp_valid}, 64'd3);
        @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("st_ifu_addr", {32'd0, mem_addr}, {32'd0, 32'h8000_0040});
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0013;
        exp_q.push_back({1'b0, 32'h0000_0013});
        drain();

        // Spurious response while IDLE.
        @(negedge clk);
        #1;
        chk("pe_before", {63'd0, proto_err}, 64'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("pe_set", {63'd0, proto_err}, 64'd1);
        chk("pe_idle", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("pe_sticky", {63'd0, proto_err}, 64'd1);

        // Reset while in RESP, then a late response and a fresh fetch.
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("rr_in_resp", {62'd0, dbg_state}, {62'd0, RESP});
        @(negedge clk);
        rst = 1'b0; ifu_req_valid = 1'b1;
        #1;
        chk("rr_outputs", {busy, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid,
                           lsu_rsp_valid, proto_err, mem_wen, mem_wmask}, 64'd0);
        chk("rr_addr_rdata", {mem_addr, ifu_rdata}, 64'd0);
        chk("rr_lsu_data", {lsu_rdata, mem_wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b1; ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0666;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("rr_late_rsp_err", {63'd0, proto_err}, 64'd1);
        run_txn(mk(1, 32'h8000_0020, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_0093, 1'b0), 1'b0, 1'b0);
        drain();

        repeat (2) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
